dram_cmd_scheduler: RTL

DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

---
 rtl/dram_cmd_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_scheduler.sv
// Single-request DRAM command scheduler with an open-page policy.
// Valid/ready: a request transfers on any clk_in edge where req_valid_in and
// req_ready_out are both high; req_ready_out is high only while the FSM is
// idle, so exactly one request is in flight and req_valid_in is otherwise
// ignored. Commands are one-cycle pulses of cmd_valid_out.
module dram_cmd_scheduler #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_LEN          = 8,
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 2,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 19,
  localparam int BG_W              = $clog2(BANK_GROUPS),
  localparam int BA_W              = $clog2(BANKS_PER_GROUP)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic [511:0]          req_data_in,
  output logic                  cmd_valid_out,
  output logic [2:0]            cmd_out,
  output logic [BG_W-1:0]       bg_out,
  output logic [BA_W-1:0]       ba_out,
  output logic [ROW_BITS-1:0]   row_out,
  output logic [COL_BITS-1:0]   col_out,
  output logic [511:0]          wdata_out,
  output logic                  busy_out,
  output logic [15:0]           row_hit_count_out,
  output logic [2:0]            state_dbg_out
);

  localparam int NB        = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BANK_W    = BG_W + BA_W;
  localparam int ADDR_USED = COL_BITS + BA_W + BG_W + ROW_BITS;
  localparam int DATA_LAT  = CAS_LATENCY + BURST_LEN;
  // A wait state spans (latency - 1) cycles; the counter counts down to zero.
  localparam int PRE_LOAD  = (PRECHARGE_LATENCY > 1) ? PRECHARGE_LATENCY - 2 : 0;
  localparam int ACT_LOAD  = (ACTIVATION_LATENCY > 1) ? ACTIVATION_LATENCY - 2 : 0;
  localparam int DATA_LOAD = (DATA_LAT > 1) ? DATA_LAT - 2 : 0;
  localparam int CNT_MAX   = (DATA_LAT > ACTIVATION_LATENCY) ?
                             ((DATA_LAT > PRECHARGE_LATENCY) ? DATA_LAT : PRECHARGE_LATENCY) :
                             ((ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY);
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_ACT   = 3'd2;
  localparam logic [2:0] CMD_PRE   = 3'd3;
  localparam logic [2:0] CMD_NONE  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_PRE, S_ACT, S_WAIT_ACT, S_ACCESS, S_WAIT_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 write_q;
  logic                 open_q [NB];
  logic [ROW_BITS-1:0]  open_row_q [NB];

  // Incoming address split: col, then bank, then bank group, then row.
  logic [COL_BITS-1:0]  in_col;
  logic [BA_W-1:0]      in_ba;
  logic [BG_W-1:0]      in_bg;
  logic [ROW_BITS-1:0]  in_row;
  logic [BANK_W-1:0]    in_bank;
  logic [BANK_W-1:0]    cur_bank;
  logic                 accept;
  logic                 in_open;
  logic                 in_hit;

  assign in_col   = req_addr_in[0 +: COL_BITS];
  assign in_ba    = req_addr_in[COL_BITS +: BA_W];
  assign in_bg    = req_addr_in[COL_BITS + BA_W +: BG_W];
  assign in_row   = req_addr_in[COL_BITS + BA_W + BG_W +: ROW_BITS];
  assign in_bank  = {in_bg, in_ba};
  assign cur_bank = {bg_out, ba_out};
  assign accept   = req_valid_in && req_ready_out;
  assign in_open  = open_q[in_bank];
  assign in_hit   = in_open && (open_row_q[in_bank] == in_row);

  // Address bits above the row field carry no meaning for this DIMM.
  logic unused_addr_bits;
  generate
    if (PADDR_BITS > ADDR_USED) begin : g_unused_addr
      assign unused_addr_bits = ^req_addr_in[PADDR_BITS-1:ADDR_USED];
    end else begin : g_no_unused_addr
      assign unused_addr_bits = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: hit goes straight to the access, closed bank activates first,
  // a row conflict precharges first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_hit)       state_d = S_ACCESS;
          else if (in_open) state_d = S_PRE;
          else              state_d = S_ACT;
        end
      end
      S_PRE:       state_d = (PRECHARGE_LATENCY > 1) ? S_WAIT_PRE : S_ACT;
      S_WAIT_PRE:  if (cnt_q == '0) state_d = S_ACT;
      S_ACT:       state_d = (ACTIVATION_LATENCY > 1) ? S_WAIT_ACT : S_ACCESS;
      S_WAIT_ACT:  if (cnt_q == '0) state_d = S_ACCESS;
      S_ACCESS:    state_d = (DATA_LAT > 1) ? S_WAIT_DATA : S_IDLE;
      S_WAIT_DATA: if (cnt_q == '0) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Command outputs: decoded from the state, fields come from the request registers.
  always_comb begin
    cmd_valid_out = 1'b0;
    cmd_out       = CMD_NONE;
    case (state_q)
      S_PRE:    begin cmd_valid_out = 1'b1; cmd_out = CMD_PRE; end
      S_ACT:    begin cmd_valid_out = 1'b1; cmd_out = CMD_ACT; end
      S_ACCESS: begin cmd_valid_out = 1'b1; cmd_out = write_q ? CMD_WRITE : CMD_READ; end
      default:  ;
    endcase
  end

  assign req_ready_out = (state_q == S_IDLE);
  assign busy_out      = (state_q != S_IDLE);
  assign state_dbg_out = state_q;

  // Wait counter: loaded while the command pulse is out, counts down in the wait state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_PRE:    cnt_q <= CNT_W'(PRE_LOAD);
        S_ACT:    cnt_q <= CNT_W'(ACT_LOAD);
        S_ACCESS: cnt_q <= CNT_W'(DATA_LOAD);
        S_WAIT_PRE, S_WAIT_ACT, S_WAIT_DATA: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default:  cnt_q <= '0;
      endcase
    end
  end

  // Request capture and row-hit statistics; write data only changes on writes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bg_out            <= '0;
      ba_out            <= '0;
      row_out           <= '0;
      col_out           <= '0;
      write_q           <= 1'b0;
      wdata_out         <= '0;
      row_hit_count_out <= '0;
    end else if (accept) begin
      bg_out  <= in_bg;
      ba_out  <= in_ba;
      row_out <= in_row;
      col_out <= in_col;
      write_q <= req_write_in;
      if (req_write_in) wdata_out <= req_data_in;
      if (in_hit && row_hit_count_out != 16'hFFFF)
        row_hit_count_out <= row_hit_count_out + 16'd1;
    end
  end

  // Open-row table: precharge closes the bank, activate opens it on the request row.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NB; i++) begin
        open_q[i]     <= 1'b0;
        open_row_q[i] <= '0;
      end
    end else if (state_q == S_PRE) begin
      open_q[cur_bank] <= 1'b0;
    end else if (state_q == S_ACT) begin
      open_q[cur_bank]     <= 1'b1;
      open_row_q[cur_bank] <= row_out;
    end
  end

endmodule
